// File: rtl/fsm_pkg.sv
// Shared definitions for the pushbutton input stages: debounce state encoding
// and default timing constants (20 ms debounce / 1 s long press at 50 MHz).
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    localparam int unsigned DEBOUNCE_COUNT_DEF = 999_999;
    localparam int unsigned LONG_COUNT_DEF     = 49_999_999;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; shared by the
// input stages. Both flops clear synchronously.
module sync_2ff (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q
);

    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (clear) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= d;
            sync_q2 <= sync_q1;
        end
    end

    assign q = sync_q2;

endmodule

// File: rtl/button_debounce_fsm.sv
// Pushbutton debouncer: synchronizer + four-state FSM producing a clean level
// and single-cycle press/release events. Long-press detection is compiled in
// with the macro BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce_fsm
    import fsm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEF,
    parameter int unsigned LONG_COUNT     = LONG_COUNT_DEF
) (
    input  logic clk,
    input  logic clear,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int unsigned CNT_W_RAW = $clog2(max_u(DEBOUNCE_COUNT, LONG_COUNT) + 1);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_COUNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_q2;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_level_q, btn_level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    sync_2ff u_sync (
        .clk   (clk),
        .clear (clear),
        .d     (btn_raw),
        .q     (sync_q2)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter only advances while waiting, and stops at DEBOUNCE_COUNT, so it cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sync_q2) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q2) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_MAX) begin
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync_q2) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q2) begin
                    state_d = HELD;
                end else if (cnt_q == DEB_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        press_d     = (state_q == PRESS_WAIT)   &&  sync_q2 && (cnt_q == DEB_MAX);
        release_d   = (state_q == RELEASE_WAIT) && !sync_q2 && (cnt_q == DEB_MAX);
        btn_level_d = btn_level_q;
        if (press_d) begin
            btn_level_d = 1'b1;
        end
        if (release_d) begin
            btn_level_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    assign btn_level     = btn_level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_COUNT);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             fired_q, fired_d;
    logic             long_q, long_d;

    // Hold count freezes in RELEASE_WAIT so a release bounce keeps it; the fired flag limits one event per press.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (press_d || release_d) begin
            hold_d  = '0;
            fired_d = 1'b0;
        end else if (state_q == HELD) begin
            if ((hold_q == LONG_MAX) && !fired_q) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end
            if (hold_q != LONG_MAX) begin
                hold_d = hold_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_fsm.sv
// Self-checking bench for button_debounce_fsm: directed scenarios followed by
// randomized bouncing input, compared every cycle against a run-length model.
module tb_button_debounce_fsm;

    localparam int unsigned DC = 4;
    localparam int unsigned LC = 20;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic clear;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    always #5 clk = ~clk;

    button_debounce_fsm #(
        .DEBOUNCE_COUNT (DC),
        .LONG_COUNT     (LC)
    ) dut (
        .clk           (clk),
        .clear         (clear),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: two-sample delay line, then the level flips once the delayed input
    // has disagreed with it for DC+2 consecutive edges.
    logic m_s1, m_s2, m_level, m_press, m_rel, m_long, m_fired;
    int   m_run, m_h;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
        m_fired = 0; m_run = 0; m_h = 0;
    endtask

    // Applies one rising edge using the inputs that were stable at that edge.
    task automatic model_step();
        logic obs;
        logic held_pre;
        if (clear) begin
            model_reset();
        end else begin
            obs      = m_s2;
            m_s2     = m_s1;
            m_s1     = btn_raw;
            held_pre = m_level && (m_run == 0);
            m_press  = 0;
            m_rel    = 0;
            m_long   = 0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            if (held_pre) begin
                if (m_h == int'(LC) && !m_fired) begin
                    m_long  = 1;
                    m_fired = 1;
                end
                if (m_h < int'(LC)) m_h++;
            end
`endif
            if (obs != m_level) begin
                m_run++;
                if (m_run == int'(DC) + 2) begin
                    m_level = obs;
                    m_run   = 0;
                    m_h     = 0;
                    if (obs) begin
                        m_press = 1;
                        m_fired = 0;
                    end else begin
                        m_rel = 1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    initial begin
        int   seg_left;
        logic long_exp;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        long_exp = 1'b1;
`else
        long_exp = 1'b0;
`endif
        clear    = 1'b1;
        btn_raw  = 1'b0;
        seg_left = 0;
        model_reset();

        for (int n = 0; n < NCYC; n++) begin
            @(negedge clk);
            cyc++;
            model_step();

            chk("level", btn_level, m_level);
            chk("press", press_pulse, m_press);
            chk("release", release_pulse, m_rel);
            chk("long", long_press, m_long);
            chk("excl", press_pulse & release_pulse, 1'b0);

            case (cyc)
                1, 77: begin
                    chk("rst_level", btn_level, 1'b0);
                    chk("rst_press", press_pulse, 1'b0);
                    chk("rst_release", release_pulse, 1'b0);
                    chk("rst_long", long_press, 1'b0);
                end
                16, 84:  chk("press_early", press_pulse, 1'b0);
                17, 85: begin
                    chk("press_edge", press_pulse, 1'b1);
                    chk("press_level", btn_level, 1'b1);
                end
                18:      chk("press_width", press_pulse, 1'b0);
                37, 39:  chk("long_quiet", long_press, 1'b0);
                38:      chk("long_edge", long_press, long_exp);
                47:      chk("release_early", release_pulse, 1'b0);
                48: begin
                    chk("release_edge", release_pulse, 1'b1);
                    chk("release_level", btn_level, 1'b0);
                end
                65:      chk("bounce_level", btn_level, 1'b0);
                74:      chk("press2_edge", press_pulse, 1'b1);
                default: ;
            endcase

            if (cyc < 120) begin
                case (cyc)
                    2:  clear   = 1'b0;
                    9:  btn_raw = 1'b1;
                    40: btn_raw = 1'b0;
                    50: btn_raw = 1'b1;
                    53: btn_raw = 1'b0;
                    55: btn_raw = 1'b1;
                    58: btn_raw = 1'b0;
                    66: btn_raw = 1'b1;
                    76: clear   = 1'b1;
                    77: clear   = 1'b0;
                    default: ;
                endcase
            end else begin
                clear = ($urandom_range(0, 199) == 0);
                if (seg_left == 0) begin
                    btn_raw  = ~btn_raw;
                    seg_left = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 45))
                                                           : int'($urandom_range(1, 10));
                end
                seg_left--;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
